pc_unit: RTL and testbench

Parametrised program-counter unit for the IF stage: successor to the single-register PC, adding start/stall gating, prioritised redirects (trap, branch, return, jump/call), a return-address stack (RAS) and a redirect flush pulse. It drives the instruction-memory address and tells IF/ID when the in-flight fetch must be killed. The hazard unit controls it through `PC_write_i`, and the control/branch logic in ID/EX through the redirect inputs.

---
 rtl/pc_pkg.sv | 41 ++++
 rtl/pc_ras.sv | 80 ++++++++
 rtl/pc_unit.sv | 134 +++++++++++++
 tb/tb_pc_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and the next-PC priority selector for the program-counter unit.
package pc_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_TRAP,
        SEL_BRANCH,
        SEL_RET,
        SEL_JUMP
    } pc_sel_t;

    // Picks the winning redirect source, highest priority first.
    // A return with nothing on the stack is escalated to a trap.
    // Callers mask branch/ret/jump themselves when the PC is stalled.
    function automatic pc_sel_t pcSelect(
        input logic trap,
        input logic branch,
        input logic ret,
        input logic jump,
        input logic rasEmpty
    );
        pc_sel_t sel;
        sel = SEL_SEQ;
        if (trap) begin
            sel = SEL_TRAP;
        end else if (branch) begin
            sel = SEL_BRANCH;
        end else if (ret) begin
            sel = rasEmpty ? SEL_TRAP : SEL_RET;
        end else if (jump) begin
            sel = SEL_JUMP;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and an occupancy
// count. Pushing onto a full stack silently overwrites the oldest entry, and a
// simultaneous push+pop replaces the top entry in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int PTRW = $clog2(RAS_DEPTH);
    localparam logic [PTRW:0] COUNT_MAX = (PTRW+1)'(RAS_DEPTH);

    logic [XLEN-1:0] r_stack [RAS_DEPTH];
    logic [PTRW-1:0] r_top;
    logic [PTRW:0]   r_count;
    logic            r_empty;
    logic            r_full;

    logic            w_doPop;
    logic            w_replace;
    logic [PTRW-1:0] w_topInc;
    logic [PTRW:0]   w_countNext;

    assign w_doPop   = pop_i && (r_count != '0);
    assign w_replace = push_i && w_doPop;
    assign w_topInc  = r_top + PTRW'(1);
    assign top_o     = r_stack[r_top];
    assign empty_o   = r_empty;
    assign full_o    = r_full;

    // Next occupancy: saturates at the depth on push, unchanged on replace.
    always_comb begin
        w_countNext = r_count;
        if (w_replace) begin
            w_countNext = r_count;
        end else if (push_i) begin
            if (r_count != COUNT_MAX) begin
                w_countNext = r_count + (PTRW+1)'(1);
            end
        end else if (w_doPop) begin
            w_countNext = r_count - (PTRW+1)'(1);
        end
    end

    // Stack storage, pointer and registered status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_top   <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_replace) begin
                r_stack[r_top] <= push_data_i;
            end else if (push_i) begin
                r_stack[w_topInc] <= push_data_i;
                r_top             <= w_topInc;
            end else if (w_doPop) begin
                r_top <= r_top - PTRW'(1);
            end
            r_count <= w_countNext;
            r_empty <= (w_countNext == '0);
            r_full  <= (w_countNext == COUNT_MAX);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: start/stall gating, prioritised redirects
// (trap, branch, return, jump/call), return-address stack and a one-cycle
// flush pulse marking every non-sequential PC load.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0080,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            PC_write_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            trap_i,
    output logic [XLEN-1:0] PC_o,
    output logic            valid_o,
    output logic            flush_o,
    output logic [XLEN-1:0] epc_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);

    pc_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_valid;
    logic            r_flush;

    logic            w_running;
    pc_sel_t         w_sel;
    logic            w_hold;
    logic [XLEN-1:0] w_pcInc;
    logic [XLEN-1:0] w_pcNext;
    logic [XLEN-1:0] w_rasTop;
    logic            w_rasEmpty;
    logic            w_rasFull;
    logic            w_push;
    logic            w_pop;

    // Only an active, started unit consumes redirect requests.
    assign w_running = (r_state == RUN) && start_i;
    assign w_sel     = pcSelect(trap_i,
                                branch_i && PC_write_i,
                                ret_i    && PC_write_i,
                                jump_i   && PC_write_i,
                                w_rasEmpty);
    assign w_hold    = !PC_write_i && (w_sel == SEL_SEQ);
    assign w_pcInc   = r_pc + XLEN'(INC);

    // A call pushes its link address whenever the jump or a return wins;
    // the return+call pairing becomes an in-place replace inside the stack.
    assign w_push = w_running && call_i && ((w_sel == SEL_JUMP) || (w_sel == SEL_RET));
    assign w_pop  = w_running && (w_sel == SEL_RET);

    // Next-PC mux driven by the winning source.
    always_comb begin
        w_pcNext = w_pcInc;
        case (w_sel)
            SEL_TRAP:   w_pcNext = TRAP_VEC;
            SEL_BRANCH: w_pcNext = branch_target_i;
            SEL_RET:    w_pcNext = w_rasTop;
            SEL_JUMP:   w_pcNext = jump_target_i;
            default:    w_pcNext = w_pcInc;
        endcase
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .push_data_i (w_pcInc),
        .top_o       (w_rasTop),
        .empty_o     (w_rasEmpty),
        .full_o      (w_rasFull)
    );

    // Run/idle FSM together with the registered PC, epc, valid and flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pc    <= RESET_VEC;
            r_epc   <= '0;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (!start_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end else if (!w_hold) begin
                        r_pc    <= w_pcNext;
                        r_flush <= (w_sel != SEL_SEQ);
                        if (w_sel == SEL_TRAP) begin
                            r_epc <= r_pc;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign PC_o        = r_pc;
    assign epc_o       = r_epc;
    assign valid_o     = r_valid;
    assign flush_o     = r_flush;
    assign ras_empty_o = w_rasEmpty;
    assign ras_full_o  = w_rasFull;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model predicts each cycle's
// outputs, queues them when stimulus is driven and compares after the edge.
module tb_pc_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        PC_write_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        call_i;
    logic        ret_i;
    logic        trap_i;
    logic [31:0] PC_o;
    logic        valid_o;
    logic        flush_o;
    logic [31:0] epc_o;
    logic        ras_empty_o;
    logic        ras_full_o;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic [31:0] epc;
        logic        empty;
        logic        full;
    } expT;

    expT         scoreboard[$];
    logic [31:0] mStack[$];
    logic [31:0] mPc;
    logic [31:0] mEpc;
    logic        mRun;
    logic        mFlush;

    pc_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .PC_write_i      (PC_write_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .call_i          (call_i),
        .ret_i           (ret_i),
        .trap_i          (trap_i),
        .PC_o            (PC_o),
        .valid_o         (valid_o),
        .flush_o         (flush_o),
        .epc_o           (epc_o),
        .ras_empty_o     (ras_empty_o),
        .ras_full_o      (ras_full_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mPc    = 32'h0;
        mEpc   = 32'h0;
        mRun   = 1'b0;
        mFlush = 1'b0;
        mStack.delete();
        scoreboard.delete();
    endtask

    task automatic applyStimulus(
        input logic        start,
        input logic        wr,
        input logic        br,
        input logic [31:0] bt,
        input logic        jp,
        input logic [31:0] jt,
        input logic        call,
        input logic        ret,
        input logic        trap
    );
        logic [31:0] link;
        expT         e;
        expT         got;
        start_i         = start;
        PC_write_i      = wr;
        branch_i        = br;
        branch_target_i = bt;
        jump_i          = jp;
        jump_target_i   = jt;
        call_i          = call;
        ret_i           = ret;
        trap_i          = trap;

        link   = mPc + 32'd4;
        mFlush = 1'b0;
        if (!mRun) begin
            if (start) mRun = 1'b1;
        end else if (!start) begin
            mRun = 1'b0;
        end else if (trap || (wr && !br && ret && mStack.size() == 0)) begin
            mEpc   = mPc;
            mPc    = 32'h80;
            mFlush = 1'b1;
        end else if (wr) begin
            if (br) begin
                mPc    = bt;
                mFlush = 1'b1;
            end else if (ret) begin
                mPc = mStack.pop_back();
                if (call) mStack.push_back(link);
                mFlush = 1'b1;
            end else if (jp) begin
                if (call) begin
                    mStack.push_back(link);
                    if (mStack.size() > 4) void'(mStack.pop_front());
                end
                mPc    = jt;
                mFlush = 1'b1;
            end else begin
                mPc = link;
            end
        end

        e.pc    = mPc;
        e.valid = mRun;
        e.flush = mFlush;
        e.epc   = mEpc;
        e.empty = (mStack.size() == 0);
        e.full  = (mStack.size() == 4);
        scoreboard.push_back(e);

        @(posedge clk_i);
        #1;
        got = scoreboard.pop_front();
        checkOutput("pc",    PC_o,        got.pc);
        checkOutput("valid", valid_o,     got.valid);
        checkOutput("flush", flush_o,     got.flush);
        checkOutput("epc",   epc_o,       got.epc);
        checkOutput("empty", ras_empty_o, got.empty);
        checkOutput("full",  ras_full_o,  got.full);
    endtask

    // Directed sequence following the block's scenarios.
    initial begin
        logic [31:0] retExp [4];
        retExp[0] = 32'h54;
        retExp[1] = 32'h44;
        retExp[2] = 32'h34;
        retExp[3] = 32'h24;

        rst_i = 1'b1;
        start_i = 0; PC_write_i = 1; branch_i = 0; branch_target_i = 0;
        jump_i = 0; jump_target_i = 0; call_i = 0; ret_i = 0; trap_i = 0;
        #2;
        modelReset();
        checkOutput("rstPc",    PC_o,        32'h0);
        checkOutput("rstValid", valid_o,     32'h0);
        checkOutput("rstFlush", flush_o,     32'h0);
        checkOutput("rstEpc",   epc_o,       32'h0);
        checkOutput("rstEmpty", ras_empty_o, 32'h1);
        checkOutput("rstFull",  ras_full_o,  32'h0);
        #1 rst_i = 1'b0;

        // Start and sequential fetch.
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("firstRunPc", PC_o, 32'h0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pcBeforeBranch", PC_o, 32'h8);

        // Branch beats jump.
        applyStimulus(1, 1, 1, 32'h100, 1, 32'h200, 0, 0, 0);
        checkOutput("branchPc", PC_o, 32'h100);
        checkOutput("branchFlush", flush_o, 32'h1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("afterBranchPc", PC_o, 32'h104);

        // Stall ignores branch but not trap.
        applyStimulus(1, 0, 1, 32'h300, 0, 0, 0, 0, 0);
        checkOutput("stallPc", PC_o, 32'h104);
        applyStimulus(1, 0, 1, 32'h300, 0, 0, 0, 0, 1);
        checkOutput("stallTrapPc", PC_o, 32'h80);
        checkOutput("stallTrapEpc", epc_o, 32'h104);

        // Five calls overflow the 4-deep stack.
        applyStimulus(1, 1, 0, 0, 1, 32'h10, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 1, 0, 0, 1, (i == 5) ? 32'h200 : 32'((i + 1) * 16), 1, 0, 0);
            if (i == 4) checkOutput("fullAfter4", ras_full_o, 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 0);
            checkOutput("retPc", PC_o, retExp[i]);
        end
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("emptyRetPc", PC_o, 32'h80);
        checkOutput("emptyRetEpc", epc_o, 32'h24);

        // Wraparound, then pause and resume.
        applyStimulus(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrapPc", PC_o, 32'h0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pauseValid", valid_o, 32'h0);
        applyStimulus(0, 1, 1, 32'h700, 0, 0, 0, 0, 1);
        checkOutput("idleIgnorePc", PC_o, 32'h4);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resumePc", PC_o, 32'h4);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Two entries on the stack, then an asynchronous reset between edges.
        applyStimulus(1, 1, 0, 0, 1, 32'h300, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 32'h400, 1, 0, 0);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("asyncRstPc",    PC_o,        32'h0);
        checkOutput("asyncRstEmpty", ras_empty_o, 32'h1);
        checkOutput("asyncRstValid", valid_o,     32'h0);
        modelReset();
        #1 rst_i = 1'b0;

        // Return+call replaces the top entry; return wins over jump.
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 32'h500, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 32'h999, 1, 1, 0);
        checkOutput("replacePc", PC_o, 32'h4);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("replacedTopPc", PC_o, 32'h504);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("finalTrapEpc", epc_o, 32'h504);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
